fb_scanout: RTL and testbench

Display scan-out engine: the read-side counterpart of the rasterizer's frame-buffer write path. Walks the frame buffer in raster order through a synchronous read port and streams pixels with horizontal/vertical sync and data-enable to the display interface. Sits between `frame_buffer`'s read port (`addr` / `data_out`) and the video output pins. Also gives the command path a vblank indication for tear-free updates.

---
 rtl/fb_scanout.sv | 133 +++++++++++++
 tb/tb_fb_scanout.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// Display scan-out engine: walks the frame buffer in raster order and
// streams pixels with hsync/vsync/data-enable two cycles behind the counters.
module fb_scanout #(
    parameter int   H_ACTIVE = 320,
    parameter int   H_FP     = 8,
    parameter int   H_SYNC   = 32,
    parameter int   H_BP     = 40,
    parameter int   V_ACTIVE = 240,
    parameter int   V_FP     = 3,
    parameter int   V_SYNC   = 4,
    parameter int   V_BP     = 6,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        fb_rd_en,
    output logic [16:0] fb_rd_addr,
    input  logic [7:0]  fb_rd_data,
    output logic [7:0]  pix_data,
    output logic        pix_de,
    output logic        hsync,
    output logic        vsync,
    output logic        vblank,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = (H_TOTAL > 2) ? $clog2(H_TOTAL) : 1;
    localparam int VW = (V_TOTAL > 2) ? $clog2(V_TOTAL) : 1;
    localparam int HS_BEG = H_ACTIVE + H_FP;
    localparam int HS_END = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_BEG = V_ACTIVE + V_FP;
    localparam int VS_END = V_ACTIVE + V_FP + V_SYNC;

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
        logic vb;
        logic fs;
    } stage_t;

    localparam stage_t IDLE = '{
        act: 1'b0,
        hs:  ~SYNC_POL,
        vs:  ~SYNC_POL,
        vb:  1'b0,
        fs:  1'b0
    };

    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic [16:0]   r_addr;
    stage_t        r_s1;
    stage_t        r_s2;
    logic [7:0]    r_pix;

    logic [31:0] w_hc;
    logic [31:0] w_vc;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_active;
    stage_t      w_s1_d;

    assign w_hc     = 32'(r_hcnt);
    assign w_vc     = 32'(r_vcnt);
    assign w_h_last = (w_hc == 32'(H_TOTAL - 1));
    assign w_v_last = (w_vc == 32'(V_TOTAL - 1));
    assign w_active = (w_hc < 32'(H_ACTIVE)) && (w_vc < 32'(V_ACTIVE));

    // Counters and address idle at the frame origin whenever scan-out is off.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
            r_addr <= '0;
        end else if (!enable) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
            r_addr <= '0;
        end else begin
            if (w_h_last) begin
                r_hcnt <= '0;
                r_vcnt <= w_v_last ? '0 : r_vcnt + VW'(1);
            end else begin
                r_hcnt <= r_hcnt + HW'(1);
            end
            if (w_h_last && w_v_last) begin
                r_addr <= '0;
            end else if (w_active) begin
                r_addr <= r_addr + 17'd1;
            end
        end
    end

    always_comb begin
        w_s1_d = IDLE;
        if (enable) begin
            w_s1_d.act = w_active;
            w_s1_d.hs  = (w_hc >= 32'(HS_BEG) && w_hc < 32'(HS_END))
                         ? SYNC_POL : ~SYNC_POL;
            w_s1_d.vs  = (w_vc >= 32'(VS_BEG) && w_vc < 32'(VS_END))
                         ? SYNC_POL : ~SYNC_POL;
            w_s1_d.vb  = (w_vc >= 32'(V_ACTIVE));
            w_s1_d.fs  = (r_hcnt == '0) && (r_vcnt == '0);
        end
    end

    // Stage 1 lines up with the read data returned by the frame buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1  <= IDLE;
            r_s2  <= IDLE;
            r_pix <= 8'h00;
        end else begin
            r_s1  <= w_s1_d;
            r_s2  <= r_s1;
            r_pix <= r_s1.act ? fb_rd_data : 8'h00;
        end
    end

    assign fb_rd_en    = w_active && enable && reset;
    assign fb_rd_addr  = r_addr;
    assign pix_data    = r_pix;
    assign pix_de      = r_s2.act;
    assign hsync       = r_s2.hs;
    assign vsync       = r_s2.vs;
    assign vblank      = r_s2.vb;
    assign frame_start = r_s2.fs;

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: small 8x6 timing, flat frame-position reference model,
// directed phases followed by random enable/reset activity.
module tb_fb_scanout;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        fb_rd_en;
    logic [16:0] fb_rd_addr;
    logic [7:0]  fb_rd_data;
    logic [7:0]  pix_data;
    logic        pix_de;
    logic        hsync;
    logic        vsync;
    logic        vblank;
    logic        frame_start;

    int errs = 0;
    int checks = 0;
    int pos = 0;
    bit hen [2];
    int hpos [2];
    int nreads, maxaddr, nde, nfs;

    fb_scanout #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .fb_rd_en(fb_rd_en),
        .fb_rd_addr(fb_rd_addr),
        .fb_rd_data(fb_rd_data),
        .pix_data(pix_data),
        .pix_de(pix_de),
        .hsync(hsync),
        .vsync(vsync),
        .vblank(vblank),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) fb_rd_data <= fb_rd_addr[7:0] ^ 8'hA5;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs for frame position p (0..47) when scan was enabled there:
    // {de, hsync, vsync, vblank, frame_start, data}
    function automatic logic [12:0] model(input bit en, input int p);
        int h, v;
        logic de;
        logic [7:0] d;
        if (!en) return {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        h  = p % 8;
        v  = p / 8;
        de = (h < 4) && (v < 3);
        d  = de ? 8'((v * 4 + h) ^ 8'hA5) : 8'h00;
        return {de, !(h >= 5 && h < 7), !(v == 4), (v >= 3), (p == 0), d};
    endfunction

    task automatic chk_idle();
        chk("rst_pix", 32'(pix_data), 32'h0);
        chk("rst_de", 32'(pix_de), 32'h0);
        chk("rst_rden", 32'(fb_rd_en), 32'h0);
        chk("rst_addr", 32'(fb_rd_addr), 32'h0);
        chk("rst_fs", 32'(frame_start), 32'h0);
        chk("rst_vb", 32'(vblank), 32'h0);
        chk("rst_hs", 32'(hsync), 32'h1);
        chk("rst_vs", 32'(vsync), 32'h1);
    endtask

    task automatic eval_cycle();
        logic [12:0] e;
        bit act;
        int h, v;
        #1;
        h   = pos % 8;
        v   = pos / 8;
        act = enable && reset && (h < 4) && (v < 3);
        chk("rd_en", 32'(fb_rd_en), 32'(act));
        if (act) begin
            chk("rd_addr", 32'(fb_rd_addr), 32'(v * 4 + h));
            nreads++;
            if (int'(fb_rd_addr) > maxaddr) maxaddr = int'(fb_rd_addr);
        end
        e = model(hen[1], hpos[1]);
        chk("pix_de", 32'(pix_de), 32'(e[12]));
        chk("hsync", 32'(hsync), 32'(e[11]));
        chk("vsync", 32'(vsync), 32'(e[10]));
        chk("vblank", 32'(vblank), 32'(e[9]));
        chk("frame_start", 32'(frame_start), 32'(e[8]));
        chk("pix_data", 32'(pix_data), 32'(e[7:0]));
        nde += int'(pix_de);
        nfs += int'(frame_start);
        hen[1]  = hen[0];
        hpos[1] = hpos[0];
        hen[0]  = enable && reset;
        hpos[0] = pos;
        @(posedge clk);
        pos = enable ? (pos + 1) % 48 : 0;
    endtask

    task automatic step(input bit en);
        @(negedge clk);
        enable = en;
        eval_cycle();
    endtask

    task automatic do_reset(input bit en_after);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_idle();
        @(negedge clk);
        reset   = 1'b1;
        enable  = en_after;
        pos     = 0;
        hen[0]  = 1'b0;
        hen[1]  = 1'b0;
        eval_cycle();
    endtask

    task automatic zero_counts();
        nreads = 0;
        maxaddr = 0;
        nde = 0;
        nfs = 0;
    endtask

    initial begin
        hen[0] = 1'b0;
        hen[1] = 1'b0;
        hpos[0] = 0;
        hpos[1] = 0;
        zero_counts();

        // Reset state, then three clean frames with enable held high
        @(negedge clk);
        #1 chk_idle();
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b1;
        pos    = 0;
        eval_cycle();
        for (int i = 1; i < 144; i++) step(1'b1);
        chk("reads_3f", 32'(nreads), 32'd36);
        chk("maxaddr_3f", 32'(maxaddr), 32'd11);
        chk("de_3f", 32'(nde), 32'd36);
        chk("fs_3f", 32'(nfs), 32'd3);

        // Mid-frame disable at line 1 pixel 2, then restart
        for (int i = 0; i < 60 && pos != 10; i++) step(1'b1);
        chk("pos_disable", 32'(pos), 32'd10);
        zero_counts();
        for (int i = 0; i < 4; i++) step(1'b0);
        chk("reads_off", 32'(nreads), 32'd0);
        for (int i = 0; i < 60; i++) step(1'b1);

        // Async reset mid-line, release with enable high
        for (int i = 0; i < 60 && pos != 2; i++) step(1'b1);
        zero_counts();
        do_reset(1'b1);
        for (int i = 1; i < 48; i++) step(1'b1);
        chk("reads_rst", 32'(nreads), 32'd12);
        chk("maxaddr_rst", 32'(maxaddr), 32'd11);

        // Random enable toggling with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset(1'($urandom_range(0, 1)));
            else step($urandom_range(0, 9) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
